// File: rtl/ram_burst_master.sv
// ---------------------------------------------------------------------------
// ram_burst_master
//
// This module is the upstream burst master for a 16x8 single-port RAM that
// uses one shared bidirectional data bus. It accepts write and read burst
// requests on a valid/ready handshake and drives the RAM's cs, wr_en, out_en
// and address pins. For writes it drives the shared bus. For reads it
// samples the bus and returns the bytes as a one-cycle pulsed stream.
//
// Ports:
//   clk, rst_n                 clock, synchronous active-low reset
//   req_valid/req_ready        burst request handshake (ready only in IDLE)
//   req_wr, req_addr, req_len  direction, start address, beats-1
//   wdata_valid/wdata_ready    write byte handshake (ready only in WR)
//   wdata                      write byte
//   rdata_valid, rdata         read byte pulse (no backpressure)
//   rdata_last                 marks the final read pulse of a burst
//   busy                       high whenever the master is not IDLE
//   ram_cs, ram_wr_en,
//   ram_out_en, ram_addr       RAM control pins
//   ram_data                   shared RAM data bus (inout)
//
// Optional build macro RAMCTL_STATS_EN:
//   wr_beats[7:0]  number of completed write beats (saturates at 255)
//   rd_beats[7:0]  number of rdata_valid pulses    (saturates at 255)
// ---------------------------------------------------------------------------
module ram_burst_master #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_wr,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [ADDR_W-1:0] req_len,
    input  logic              wdata_valid,
    output logic              wdata_ready,
    input  logic [DATA_W-1:0] wdata,
    output logic              rdata_valid,
    output logic [DATA_W-1:0] rdata,
    output logic              rdata_last,
    output logic              busy,
    output logic              ram_cs,
    output logic              ram_wr_en,
    output logic              ram_out_en,
    output logic [ADDR_W-1:0] ram_addr,
`ifdef RAMCTL_STATS_EN
    output logic [7:0]        wr_beats,
    output logic [7:0]        rd_beats,
`endif
    inout  wire  [DATA_W-1:0] ram_data
);

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_WR       = 3'd1;
    localparam logic [2:0] S_RD_PRIME = 3'd2;
    localparam logic [2:0] S_RD_DATA  = 3'd3;
    localparam logic [2:0] S_TURN     = 3'd4;

    logic [2:0]        state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [ADDR_W-1:0] beat_q, beat_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              rdata_valid_q, rdata_valid_d;
    logic              rdata_last_q, rdata_last_d;

    // Raw, ungated versions of the combinational outputs.
    logic              wready_c;
    logic              cs_c;
    logic              we_c;
    logic              oe_c;
    logic              drive_c;

    always_comb begin
        state_d       = state_q;
        addr_d        = addr_q;
        beat_d        = beat_q;
        rdata_d       = rdata_q;
        rdata_valid_d = 1'b0;
        rdata_last_d  = 1'b0;
        wready_c      = 1'b0;
        cs_c          = 1'b0;
        we_c          = 1'b0;
        oe_c          = 1'b0;
        drive_c       = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    addr_d  = req_addr;
                    beat_d  = req_len;
                    state_d = req_wr ? S_WR : S_RD_PRIME;
                end
            end

            S_WR: begin
                wready_c = 1'b1;
                if (wdata_valid) begin
                    cs_c    = 1'b1;
                    we_c    = 1'b1;
                    drive_c = 1'b1;
                    addr_d  = addr_q + 1'b1;
                    if (beat_q == '0) begin
                        state_d = S_IDLE;
                    end else begin
                        beat_d = beat_q - 1'b1;
                    end
                end
            end

            S_RD_PRIME: begin
                cs_c    = 1'b1;
                state_d = S_RD_DATA;
                // The address advances only if another RAM read follows.
                // On the final data cycle the address stays on the last
                // beat's address, so the RAM never reads past the burst.
                if (beat_q != '0) begin
                    addr_d = addr_q + 1'b1;
                end
            end

            S_RD_DATA: begin
                cs_c          = 1'b1;
                oe_c          = 1'b1;
                rdata_d       = ram_data;
                rdata_valid_d = 1'b1;
                rdata_last_d  = (beat_q == '0);
                if (beat_q == '0) begin
                    state_d = S_TURN;
                end else begin
                    beat_d = beat_q - 1'b1;
                    if (beat_q != {{(ADDR_W-1){1'b0}}, 1'b1}) begin
                        addr_d = addr_q + 1'b1;
                    end
                end
            end

            S_TURN: begin
                // This is a dead bus cycle. The RAM has released the bus
                // before the master can drive it again.
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= S_IDLE;
            addr_q        <= '0;
            beat_q        <= '0;
            rdata_q       <= '0;
            rdata_valid_q <= 1'b0;
            rdata_last_q  <= 1'b0;
        end else begin
            state_q       <= state_d;
            addr_q        <= addr_d;
            beat_q        <= beat_d;
            rdata_q       <= rdata_d;
            rdata_valid_q <= rdata_valid_d;
            rdata_last_q  <= rdata_last_d;
        end
    end

    // All outputs are qualified with rst_n. An asserted reset therefore
    // releases the bus and silences every control in the same cycle, not
    // only after the next edge.
    assign req_ready   = rst_n & (state_q == S_IDLE);
    assign busy        = rst_n & (state_q != S_IDLE);
    assign wdata_ready = rst_n & wready_c;
    assign ram_cs      = rst_n & cs_c;
    assign ram_wr_en   = rst_n & we_c;
    assign ram_out_en  = rst_n & oe_c;
    assign ram_addr    = rst_n ? addr_q : '0;
    assign rdata_valid = rst_n & rdata_valid_q;
    assign rdata_last  = rst_n & rdata_last_q;
    assign rdata       = rst_n ? rdata_q : '0;

    assign ram_data    = (rst_n & drive_c) ? wdata : {DATA_W{1'bz}};

`ifdef RAMCTL_STATS_EN
    logic [7:0] wr_beats_q, wr_beats_d;
    logic [7:0] rd_beats_q, rd_beats_d;

    always_comb begin
        wr_beats_d = wr_beats_q;
        rd_beats_d = rd_beats_q;
        if ((state_q == S_WR) && wdata_valid && (wr_beats_q != 8'hFF)) begin
            wr_beats_d = wr_beats_q + 8'd1;
        end
        if (rdata_valid_q && (rd_beats_q != 8'hFF)) begin
            rd_beats_d = rd_beats_q + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_beats_q <= 8'd0;
            rd_beats_q <= 8'd0;
        end else begin
            wr_beats_q <= wr_beats_d;
            rd_beats_q <= rd_beats_d;
        end
    end

    assign wr_beats = wr_beats_q;
    assign rd_beats = rd_beats_q;
`endif

endmodule

// File: doc/ram_burst_master.md
Name: ram_burst_master

Overview:
- Upstream bus master for the 16x8 single-port RAM with the shared bidirectional 8-bit data bus.
- Accepts write or read burst requests on a valid/ready interface and sequences the RAM's cs / wr_en / out_en / address pins.
- Drives the shared data bus for writes and samples it for reads.
- Delivers read bytes as a pulsed stream and inserts bus turnaround so the controller and RAM never drive the bus together.

Parameters:
- ADDR_W, 4, RAM address width; burst addresses wrap modulo 2**ADDR_W.
- DATA_W, 8, RAM data / bus width.

Ports:
- clk  input  1  single clock, all logic on posedge.
- rst_n  input  1  synchronous active-low reset.
- req_valid  input  1  burst request present.
- req_ready  output  1  master can accept a request; high only in IDLE.
- req_wr  input  1  1 = write burst, 0 = read burst.
- req_addr  input  ADDR_W  burst start address.
- req_len  input  ADDR_W  beats minus 1; 0 = 1 beat, 15 = 16 beats.
- wdata_valid  input  1  write byte present.
- wdata_ready  output  1  write byte accepted this cycle.
- wdata  input  DATA_W  write byte.
- rdata_valid  output  1  one-cycle pulse, rdata valid; no backpressure.
- rdata  output  DATA_W  read byte.
- rdata_last  output  1  qualifies the final rdata_valid pulse of a burst.
- busy  output  1  high whenever state is not IDLE.
- ram_cs  output  1  RAM chip select.
- ram_wr_en  output  1  RAM write enable.
- ram_out_en  output  1  RAM output enable.
- ram_addr  output  ADDR_W  RAM address.
- ram_data  inout  DATA_W  shared RAM data bus.

Behaviour:
- Clock is clk; reset is rst_n, synchronous and active-low. All state changes occur on the posedge only.
- Reset values:
  - State = IDLE.
  - req_ready = 0 during reset, 1 on the first cycle after release.
  - wdata_ready, rdata_valid, rdata_last, busy, ram_cs, ram_wr_en, ram_out_en = 0.
  - rdata = 0, ram_addr = 0, ram_data = Z.
- Reset asserted mid-burst aborts the burst. Remaining beats are discarded and the bus is released on the reset cycle.
- States: IDLE, WR, RD_PRIME, RD_DATA, TURN.
- IDLE:
  - req_ready = 1.
  - On req_valid, latch req_addr into the address counter and req_len into the beat counter.
  - Go to WR if req_wr = 1, else RD_PRIME.
- WR:
  - wdata_ready = 1.
  - On a cycle with wdata_valid: ram_cs = ram_wr_en = 1, ram_data = wdata, ram_addr = current address.
  - The RAM writes at the clock edge ending that cycle. After the beat, the address increments (wrapping 15 -> 0) and the beat counter decrements.
  - On a cycle without wdata_valid: ram_cs = 0 and ram_data = Z (stall, no write).
  - After the last beat, go to IDLE. One beat per cycle maximum.
- RD_PRIME (1 cycle):
  - ram_cs = 1, ram_wr_en = 0, ram_out_en = 0, ram_addr = start address. The RAM loads its read register at the edge.
  - Address increments. Go to RD_DATA.
- RD_DATA (len+1 cycles):
  - ram_cs = 1, ram_wr_en = 0, ram_out_en = 1, ram_addr = next address. On the final cycle, ram_addr holds the last beat's address.
  - The master samples ram_data at the edge. The following cycle, rdata = sampled byte and rdata_valid = 1.
  - Throughput is 1 byte per cycle after the prime cycle. First-byte latency is 3 cycles from request acceptance.
  - After the last beat, go to TURN.
- TURN (1 cycle):
  - All RAM controls are 0 and ram_data = Z. Guarantees a dead cycle before any subsequent write.
  - Go to IDLE. The final rdata_valid / rdata_last pulse coincides with TURN.
- Bus drive rule: the master drives ram_data only when ram_cs & ram_wr_en. ram_out_en and ram_wr_en are never both 1.
- The address counter is ADDR_W bits and wraps; a burst with addr + len > 15 continues at 0.
- req_valid is ignored outside IDLE. Requests are never queued.
- wdata_valid is ignored outside WR.

Optional Feature:
- Macro: RAMCTL_STATS_EN.
- When defined, two extra outputs are added:
  - wr_beats[7:0]: count of completed write beats.
  - rd_beats[7:0]: count of rdata_valid pulses.
- Both counters reset to 0 on rst_n, saturate at 255, and never wrap.
- When not defined, the ports and counters are absent and all other behaviour is identical.

Test Plan:
- Reset then idle: rst_n low for 2 cycles -> req_ready = 0, ram_data = Z; cycle after release req_ready = 1, busy = 0, all RAM controls 0.
- Write burst, addr 4, len 3, bytes A1,B2,C3,D4 back-to-back -> four consecutive writes to addr 4,5,6,7; wdata_ready high for 4 cycles; then IDLE.
- Read burst, addr 4, len 3 -> RD_PRIME then 4 RD_DATA cycles; rdata pulses A1,B2,C3,D4 on consecutive cycles, rdata_last with D4; one TURN cycle with bus Z.
- Wrap plus stall: write addr 14, len 2, with wdata_valid low for 1 cycle between beats -> writes to 14,15,0; ram_cs = 0 during the stall; readback of addr 14, len 2 returns the same three bytes.
- Read then write: read request immediately followed by a write request -> TURN cycle present, no cycle with ram_out_en = 1 while the master drives, first write lands at least 2 cycles after the last RD_DATA.
- Reset mid-read: rst_n low during the second RD_DATA of a 16-beat read -> no further rdata_valid, all controls 0, bus Z, req_ready = 1 the cycle after release; with RAMCTL_STATS_EN, rd_beats = 0.
